lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_align.sv | 29 ++
 rtl/lsu_ctrl.sv | 92 +++++++++
 tb/tb_lsu_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared states, RV32I funct3 codes and memory geometry for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int MEM_BYTES = 4096;
  function automatic logic legal_f3(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extraction/extension from the MSB-first memory word and sub-word store merge
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rd_word[DATA_WIDTH-1 -: 8];
  assign h = rd_word[DATA_WIDTH-1 -: 16];
  // the addressed byte/half sits at the top of the word because memory returns B[a] as the MSB
  always_comb begin
    load_data  = funct3 == F3_B  ? {{(DATA_WIDTH-8){b[7]}}, b}
               : funct3 == F3_BU ? {{(DATA_WIDTH-8){1'b0}}, b}
               : funct3 == F3_H  ? {{(DATA_WIDTH-16){h[15]}}, h}
               : funct3 == F3_HU ? {{(DATA_WIDTH-16){1'b0}}, h}
               : rd_word;
    store_data = funct3 == F3_B ? {wdata[7:0], base[DATA_WIDTH-9:0]}
               : funct3 == F3_H ? {wdata[15:0], base[DATA_WIDTH-17:0]}
               : wdata;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller with read-modify-write sub-word stores (optional LSU_ALIGN_CHECK_EN)
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_add,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r, rdata_r, word_r, load_data, store_data;
  logic [2:0] f3_r;
  logic we_r, err_r, accept, fault, misalign;
  assign accept = state == IDLE && req_valid;
`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign fault = !legal_f3(req_we, req_funct3) || req_addr > 32'(MEM_BYTES - 4) || misalign;
  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3(f3_r),
    .rd_word(mem_dataout),
    .base(word_r),
    .wdata(wdata_r),
    .load_data(load_data),
    .store_data(store_data)
  );
  // state and request registers; load data and RMW base word are captured on their read cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      we_r    <= 1'b0;
      f3_r    <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      word_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        addr_r  <= req_addr[ADDR_WIDTH-1:0];
        we_r    <= req_we;
        f3_r    <= req_funct3;
        wdata_r <= req_wdata;
        rdata_r <= '0;
        err_r   <= fault;
      end
      if (state == LOAD) rdata_r <= load_data;
      if (state == RMW_RD) word_r <= mem_dataout;
    end
  end
  // next-state decode and Moore outputs; faults skip straight to the response
  always_comb begin
    next       = state;
    req_ready  = state == IDLE;
    rsp_valid  = state == RESP;
    mem_ren    = state == LOAD || state == RMW_RD;
    mem_wen    = we_r && (state == ST_WORD || state == RMW_WR);
    mem_datain = state == ST_WORD ? wdata_r : state == RMW_WR ? store_data : '0;
    unique case (state)
      IDLE:    if (req_valid) next = fault ? RESP : !req_we ? LOAD : req_funct3 == F3_W ? ST_WORD : RMW_RD;
      LOAD:    next = RESP;
      ST_WORD: next = RESP;
      RMW_RD:  next = RMW_WR;
      RMW_WR:  next = RESP;
      RESP:    if (rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign mem_add   = addr_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl against a byte-array memory model
module tb_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic mem_ren, mem_wen;
  logic [11:0] mem_add;
  logic [31:0] mem_datain, mem_dataout;
  logic [7:0] mem [0:4098];
  int checks = 0, fails = 0, wen_cnt = 0, ren_cnt = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_add(mem_add),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  assign mem_dataout = {mem[int'(mem_add)], mem[int'(mem_add)+1], mem[int'(mem_add)+2], mem[int'(mem_add)+3]};

  always @(posedge clk) begin
    if (mem_wen) begin
      wen_cnt <= wen_cnt + 1;
      mem[int'(mem_add)]   <= mem_datain[31:24];
      mem[int'(mem_add)+1] <= mem_datain[23:16];
      mem[int'(mem_add)+2] <= mem_datain[15:8];
      mem[int'(mem_add)+3] <= mem_datain[7:0];
    end
    if (mem_ren) ren_cnt <= ren_cnt + 1;
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_ren, mem_wen} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, rsp_valid, rsp_err, mem_ren, mem_wen});
    end
    checks++;
    if ({rsp_rdata, mem_add, mem_datain} !== 76'h0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h want 0", rsp_rdata, mem_add, mem_datain);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b010};
    logic [31:0] ad  [6] = '{32'h010, 32'h010, 32'h010, 32'h010, 32'h010, 32'hFFC};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012, 32'h80123456, 32'h11223344};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      checks++;
      if ({mem_ren, mem_wen, rsp_valid, req_ready} !== 4'b1000 || mem_add !== ad[i][11:0]) begin
        fails++; $display("FAIL load%0d_t1 got ren/wen/vld/rdy=%b add=%h want 1000 add=%h", i, {mem_ren, mem_wen, rsp_valid, req_ready}, mem_add, ad[i][11:0]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp[i]) begin
        fails++; $display("FAIL load%0d_t2 got vld=%b err=%b data=%h want 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exp[i]);
      end
      release_rsp;
    end
  endtask

  task automatic test_backpressure;
    int w0 = wen_cnt;
    issue(1'b0, 3'b010, 32'h010, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80123456 || req_ready !== 1'b0 || rsp_err !== 1'b0) begin
        fails++; $display("FAIL hold%0d got vld=%b data=%h rdy=%b err=%b want 1 80123456 0 0", i, rsp_valid, rsp_rdata, req_ready, rsp_err);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    release_rsp;
    checks++;
    if (wen_cnt - w0 !== 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL ignore_req got wen=%0d rdy=%b want 0 1", wen_cnt - w0, req_ready);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int w0 = wen_cnt;
    issue(1'b1, 3'b001, 32'h010, 32'h0000BEEF);
    checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
      fails++; $display("FAIL rmw_rd got ren=%b wen=%b want 1 0", mem_ren, mem_wen);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, mem_wen, mem_ren} !== 4'b1000) begin
      fails++; $display("FAIL rst_mid got rdy/vld/wen/ren=%b want 1000", {req_ready, rsp_valid, mem_wen, mem_ren});
    end
    @(negedge clk);
    issue(1'b0, 3'b010, 32'h010, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'h80123456 || wen_cnt - w0 !== 0) begin
      fails++; $display("FAIL rst_mem got data=%h wen=%0d want 80123456 0", rsp_rdata, wen_cnt - w0);
    end
    release_rsp;
  endtask

  task automatic test_faults;
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [5] = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b110};
    logic [31:0] ad [5] = '{32'hFFD, 32'hFFD, 32'h010, 32'h010, 32'h010};
    for (int i = 0; i < 5; i++) begin
      int w0 = wen_cnt, r0 = ren_cnt;
      issue(we[i], f3[i], ad[i], 32'h12345678);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
        fails++; $display("FAIL fault%0d got vld=%b err=%b data=%h want 1 1 0", i, rsp_valid, rsp_err, rsp_rdata);
      end
      release_rsp;
      checks++;
      if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0) begin
        fails++; $display("FAIL fault%0d_strobe got wen=%0d ren=%0d want 0 0", i, wen_cnt - w0, ren_cnt - r0);
      end
    end
  endtask

  task automatic test_misalign;
    issue(1'b0, 3'b001, 32'h011, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL lh_misalign got vld=%b err=%b data=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
`else
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00001234) begin
      fails++; $display("FAIL lh_misalign got vld=%b err=%b data=%h want 1 0 00001234", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
    release_rsp;
    issue(1'b0, 3'b010, 32'h011, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      fails++; $display("FAIL lw_misalign got vld=%b err=%b want 1 1", rsp_valid, rsp_err);
    end
`else
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345677) begin
      fails++; $display("FAIL lw_misalign got vld=%b err=%b data=%h want 1 0 12345677", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
    release_rsp;
  endtask

  task automatic test_stores;
    issue(1'b1, 3'b000, 32'h011, 32'h000000AB);
    checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin
      fails++; $display("FAIL sb_t1 got ren=%b wen=%b want 1 0", mem_ren, mem_wen);
    end
    @(negedge clk);
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_datain !== 32'hAB345677 || mem_add !== 12'h011) begin
      fails++; $display("FAIL sb_t2 got wen=%b ren=%b din=%h add=%h want 1 0 AB345677 011", mem_wen, mem_ren, mem_datain, mem_add);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || mem_wen !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL sb_t3 got vld=%b wen=%b err=%b data=%h want 1 0 0 0", rsp_valid, mem_wen, rsp_err, rsp_rdata);
    end
    release_rsp;
    issue(1'b0, 3'b010, 32'h010, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'h80AB3456) begin
      fails++; $display("FAIL sb_readback got %h want 80AB3456", rsp_rdata);
    end
    release_rsp;
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    checks++;
    if (mem_wen !== 1'b1 || mem_datain !== 32'hDEADBEEF) begin
      fails++; $display("FAIL sw_t1 got wen=%b din=%h want 1 DEADBEEF", mem_wen, mem_datain);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL sw_t2 got vld=%b data=%h err=%b want 1 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    release_rsp;
    issue(1'b1, 3'b001, 32'h100, 32'h1234CAFE);
    repeat (2) @(negedge clk);
    release_rsp;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'hCAFEBEEF) begin
      fails++; $display("FAIL sh_readback got %h want CAFEBEEF", rsp_rdata);
    end
    release_rsp;
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h010;
    @(posedge clk); @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_idle got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_ren !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_reaccept got ren=%b rdy=%b want 1 0", mem_ren, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AB3456) begin
      fails++; $display("FAIL b2b_data got vld=%b data=%h want 1 80AB3456", rsp_valid, rsp_rdata);
    end
    release_rsp;
  endtask

  initial begin
    for (int i = 0; i < 4099; i++) mem[i] = 8'h00;
    mem[16] = 8'h80; mem[17] = 8'h12; mem[18] = 8'h34; mem[19] = 8'h56; mem[20] = 8'h77;
    mem[4092] = 8'h11; mem[4093] = 8'h22; mem[4094] = 8'h33; mem[4095] = 8'h44;
    @(negedge clk);
    test_reset;
    test_loads;
    test_backpressure;
    test_reset_mid_rmw;
    test_faults;
    test_misalign;
    test_stores;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
